// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - register writeback FIFO with pending-write forwarding
module reg_writeback_queue #(
   parameter int DEPTH   = 4,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        hold,
   input  logic        in_valid,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        regWrite,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   output logic        rsPending,
   output logic        rtPending,
   output logic [31:0] rsFwd,
   output logic [31:0] rtFwd
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

   logic [4:0]    mem_reg_q  [DEPTH];
   logic [31:0]   mem_data_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic          regwrite_q;
   logic [4:0]    writereg_q;
   logic [31:0]   writedata_q;

   logic          push_fire, enq, pop;

   // A push handshake completes whenever the queue has room; r0 writes are
   // swallowed without occupying a slot when DROP_R0 is set.
   assign in_ready  = (count_q < DEPTH_C);
   assign push_fire = in_valid && in_ready && !flush;
   assign enq       = push_fire && !(DROP_R0 && (in_reg == 5'd0));
   assign pop       = (count_q != '0) && !hold && !flush;

   assign regWrite  = regwrite_q;
   assign writeReg  = writereg_q;
   assign writeData = writedata_q;

   // Occupancy next state from the push/pop pair
   always_comb begin
      count_d = count_q;
      case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write; contents are not reset, only pointers/count are
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_reg_q[wr_ptr_q]  <= in_reg;
         mem_data_q[wr_ptr_q] <= in_data;
      end
   end

   // Pointers, occupancy and registered write-port stage; rst beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else if (flush) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         regwrite_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            regwrite_q  <= 1'b1;
            writereg_q  <= mem_reg_q[rd_ptr_q];
            writedata_q <= mem_data_q[rd_ptr_q];
         end else begin
            regwrite_q <= 1'b0;
         end
      end
   end

   // Scan output stage first, then FIFO oldest to newest so the youngest match wins
   function automatic logic [32:0] lookup(input logic [4:0] q);
      logic          hit;
      logic [31:0]   d;
      logic [PW-1:0] idx;
      hit = regwrite_q && (writereg_q == q);
      d   = hit ? writedata_q : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (((PW + 1)'(i) < count_q) && (mem_reg_q[idx] == q)) begin
            hit = 1'b1;
            d   = mem_data_q[idx];
         end
      end
      if (DROP_R0 && (q == 5'd0)) begin
         hit = 1'b0;
         d   = 32'd0;
      end
      return {hit, d};
   endfunction

   // Operand hazard queries against the pending set
   always_comb begin
      {rsPending, rsFwd} = lookup(rs);
      {rtPending, rtFwd} = lookup(rt);
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;

   logic        clk = 1'b0;
   logic        rst, flush, hold, in_valid;
   logic [4:0]  in_reg, rs, rt;
   logic [31:0] in_data;
   logic        in_ready, regWrite, rsPending, rtPending;
   logic [4:0]  writeReg;
   logic [31:0] writeData, rsFwd, rtFwd;

   int n_cmp = 0;
   int n_err = 0;

   reg_writeback_queue #(.DEPTH(4), .DROP_R0(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data), .in_ready(in_ready),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .rs(rs), .rt(rt), .rsPending(rsPending), .rtPending(rtPending),
      .rsFwd(rsFwd), .rtFwd(rtFwd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running required finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
      in_reg = '0; in_data = '0; rs = 5'd5; rt = 5'd0;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL reset_regWrite got %0b want 0", regWrite); end
      n_cmp++; if (writeReg !== 5'd0) begin n_err++; $display("FAIL reset_writeReg got %0d want 0", writeReg); end
      n_cmp++; if (writeData !== 32'd0) begin n_err++; $display("FAIL reset_writeData got %h want 0", writeData); end
      n_cmp++; if ({rsPending, rsFwd} !== 33'd0) begin n_err++; $display("FAIL reset_rs got %0b/%h want 0/0", rsPending, rsFwd); end
   endtask

   task automatic test_latency();
      in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h0000_00AA; rs = 5'd5;
      tick();
      in_valid = 1'b0;
      #1;
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL lat_early_regWrite got %0b want 0", regWrite); end
      n_cmp++; if ({rsPending, rsFwd} !== {1'b1, 32'hAA}) begin n_err++; $display("FAIL lat_fifo_fwd got %0b/%h want 1/aa", rsPending, rsFwd); end
      tick();
      n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd5, 32'hAA}) begin n_err++; $display("FAIL lat_out got %0b/%0d/%h want 1/5/aa", regWrite, writeReg, writeData); end
      n_cmp++; if ({rsPending, rsFwd} !== {1'b1, 32'hAA}) begin n_err++; $display("FAIL lat_stage_fwd got %0b/%h want 1/aa", rsPending, rsFwd); end
      tick();
      n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b0, 5'd5, 32'hAA}) begin n_err++; $display("FAIL lat_one_cycle got %0b/%0d/%h want 0/5/aa", regWrite, writeReg, writeData); end
      n_cmp++; if (rsPending !== 1'b0) begin n_err++; $display("FAIL lat_committed_pending got %0b want 0", rsPending); end
   endtask

   task automatic test_hold_full();
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_reg = 5'(i); in_data = 32'h100 + 32'(i);
         tick();
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
      in_reg = 5'd9; in_data = 32'h999; rs = 5'd9;
      tick();
      in_valid = 1'b0;
      #1;
      n_cmp++; if ({in_ready, regWrite} !== 2'b00) begin n_err++; $display("FAIL full_held got %b want 00", {in_ready, regWrite}); end
      n_cmp++; if (rsPending !== 1'b0) begin n_err++; $display("FAIL full_ignored_pending got %0b want 0", rsPending); end
      hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'(i), 32'h100 + 32'(i)}) begin
            n_err++; $display("FAIL drain_order[%0d] got %0b/%0d/%h want 1/%0d/%h", i, regWrite, writeReg, writeData, i, 32'h100 + 32'(i));
         end
      end
      tick();
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL drain_end got %0b want 0", regWrite); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'h1111_1111 * 32'(i + 1);
         tick();
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
         if (i > 0) begin
            n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'(9 + i), 32'h1111_1111 * 32'(i)}) begin
               n_err++; $display("FAIL b2b_out[%0d] got %0b/%0d/%h want 1/%0d/%h", i, regWrite, writeReg, writeData, 9 + i, 32'h1111_1111 * 32'(i));
            end
         end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd15, 32'h6666_6666}) begin n_err++; $display("FAIL b2b_last got %0b/%0d/%h want 1/15/66666666", regWrite, writeReg, writeData); end
      tick();
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %0b want 0", regWrite); end
   endtask

   task automatic test_forward();
      hold = 1'b1;
      in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h11; tick();
      in_data = 32'h22; tick();
      in_valid = 1'b0; rs = 5'd7; rt = 5'd8;
      #1;
      n_cmp++; if ({rsPending, rsFwd} !== {1'b1, 32'h22}) begin n_err++; $display("FAIL fwd_rs got %0b/%h want 1/22", rsPending, rsFwd); end
      n_cmp++; if ({rtPending, rtFwd} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL fwd_rt got %0b/%h want 0/0", rtPending, rtFwd); end
      hold = 1'b0;
      tick();
      n_cmp++; if ({regWrite, writeData, rsPending, rsFwd} !== {1'b1, 32'h11, 1'b1, 32'h22}) begin n_err++; $display("FAIL fwd_fifo_over_stage got %0b/%h/%0b/%h want 1/11/1/22", regWrite, writeData, rsPending, rsFwd); end
      tick();
      n_cmp++; if ({regWrite, writeData, rsPending, rsFwd} !== {1'b1, 32'h22, 1'b1, 32'h22}) begin n_err++; $display("FAIL fwd_stage_only got %0b/%h/%0b/%h want 1/22/1/22", regWrite, writeData, rsPending, rsFwd); end
      tick();
      n_cmp++; if ({rsPending, rsFwd} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL fwd_cleared got %0b/%h want 0/0", rsPending, rsFwd); end
   endtask

   task automatic test_drop_r0();
      hold = 1'b1;
      in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF_FFFF; rs = 5'd0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_handshake got %0b want 1", in_ready); end
      tick();
      n_cmp++; if ({rsPending, rsFwd} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL r0_query got %0b/%h want 0/0", rsPending, rsFwd); end
      for (int i = 0; i < 3; i++) begin
         in_reg = 5'(21 + i); in_data = 32'hC0 + 32'(i);
         tick();
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_not_counted got %0b want 1", in_ready); end
      in_reg = 5'd24; in_data = 32'hC3;
      tick();
      n_cmp++; if ({in_ready, regWrite} !== 2'b00) begin n_err++; $display("FAIL r0_full got %b want 00", {in_ready, regWrite}); end
   endtask

   task automatic test_flush();
      flush = 1'b1; in_valid = 1'b1; in_reg = 5'd25; in_data = 32'hDEAD;
      tick();
      flush = 1'b0; in_valid = 1'b0; rs = 5'd21; rt = 5'd25;
      #1;
      n_cmp++; if ({in_ready, regWrite} !== 2'b10) begin n_err++; $display("FAIL flush_state got %b want 10", {in_ready, regWrite}); end
      n_cmp++; if ({rsPending, rtPending} !== 2'b00) begin n_err++; $display("FAIL flush_pending got %b want 00", {rsPending, rtPending}); end
      hold = 1'b0;
      tick(); tick();
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL flush_no_write got %0b want 0", regWrite); end
   endtask

   task automatic test_reset_mid_drain();
      hold = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_reg = 5'(i); in_data = 32'hA0 + 32'(i);
         tick();
      end
      in_valid = 1'b0; hold = 1'b0;
      tick();
      n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd1, 32'hA1}) begin n_err++; $display("FAIL mid_drain got %0b/%0d/%h want 1/1/a1", regWrite, writeReg, writeData); end
      rst = 1'b1;
      tick();
      rst = 1'b0; rs = 5'd2;
      #1;
      n_cmp++; if ({regWrite, writeReg, writeData} !== {1'b0, 5'd0, 32'd0}) begin n_err++; $display("FAIL rst_drain got %0b/%0d/%h want 0/0/0", regWrite, writeReg, writeData); end
      n_cmp++; if ({in_ready, rsPending} !== 2'b10) begin n_err++; $display("FAIL rst_ready_pending got %b want 10", {in_ready, rsPending}); end
      tick(); tick();
      n_cmp++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL rst_no_more got %0b want 0", regWrite); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_hold_full();
      test_back_to_back();
      test_forward();
      test_drop_r0();
      test_flush();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write entries (power of two, 2..16).
REQ-002 Parameter DROP_R0, default 1, when 1 writes targeting register 0 are accepted and discarded.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all queued and staged writes.
REQ-006 hold  input  1  when 1, no entry is popped to the write port this cycle.
REQ-007 in_valid  input  1  producer offers a write request.
REQ-008 in_reg  input  5  destination register index of offered request.
REQ-009 in_data  input  32  write data of offered request.
REQ-010 in_ready  output  1  queue can accept a request this cycle.
REQ-011 regWrite  output  1  registered write strobe to the register-file write port.
REQ-012 writeReg  output  5  registered destination index to the register-file write port.
REQ-013 writeData  output  32  registered write data to the register-file write port.
REQ-014 rs, rt  input  5 each  operand indices queried against pending writes.
REQ-015 rsPending, rtPending  output  1 each  a not-yet-committed write to rs / rt exists.
REQ-016 rsFwd, rtFwd  output  32 each  data of the youngest pending write to rs / rt; 0 when none.

Function
REQ-017 Storage: circular FIFO of DEPTH entries {reg[4:0], data[31:0]}, read pointer, write pointer, occupancy count 0..DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH) and not depend combinationally on in_valid; no same-cycle bypass when full.
REQ-019 Push: at a posedge with in_valid && in_ready && !flush, entry enqueued at write pointer, pointer wraps DEPTH-1 -> 0.
REQ-020 When DROP_R0=1 and in_reg=0, handshake completes but nothing is enqueued and count is unchanged.
REQ-021 Pop: at a posedge with count>0 && !hold && !flush, head entry loads writeReg/writeData, regWrite<=1, read pointer advances with wrap.
REQ-022 At a posedge with no pop, regWrite<=0; writeReg/writeData retain previous values.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance; legal at any count including DEPTH-1 and (pop side) DEPTH.
REQ-024 Latency: request accepted at edge k into an empty queue with hold=0 SHALL show regWrite=1 in the cycle following edge k+1; register file commits at edge k+2.
REQ-025 Order: writes leave in exact acceptance order; one write per cycle maximum.
REQ-026 Pending set = all valid FIFO entries plus the output stage while regWrite=1.
REQ-027 rsPending/rsFwd (and rt equivalents) combinational over the pending set; youngest match wins (newest FIFO entry, then oldest, then output stage).
REQ-028 Queries with rs or rt = 0 SHALL report pending=0, fwd=0 when DROP_R0=1.
REQ-029 flush: at the posedge, count<=0, pointers<=0, regWrite<=0; flush overrides push, pop and hold; in_ready=1 the following cycle.

Reset
REQ-030 rst at a posedge: count=0, pointers=0, regWrite=0, writeReg=0, writeData=0; FIFO contents need not clear.
REQ-031 rst has priority over flush, push and pop, including mid-drain; after reset in_ready=1, all pending outputs 0.

Verification
REQ-032 Reset, then push {r5,0x0000_00AA} with hold=0 -> two cycles later regWrite=1, writeReg=5, writeData=0xAA for exactly one cycle.
REQ-033 hold=1, push 4 entries r1..r4 -> in_ready=0 after 4th; 5th in_valid ignored; release hold -> r1..r4 appear on consecutive cycles in order.
REQ-034 Queue {r7,0x11},{r7,0x22} under hold, rs=7 -> rsPending=1, rsFwd=0x22; rt=8 -> rtPending=0, rtFwd=0.
REQ-035 DROP_R0=1, push {r0,0xFFFF_FFFF} -> in_ready handshake completes, count stays 0, regWrite never asserts.
REQ-036 Full queue with flush and in_valid asserted same edge -> next cycle count=0, regWrite=0, in_ready=1, no entry enqueued.
REQ-037 rst asserted while regWrite=1 mid-drain of 3 entries -> next cycle regWrite=0, writeReg=0, writeData=0, no further writes emitted.
